// File: rtl/nonrestoring_divider_if.sv
// Start/done handshake bundle between a requester and the non-restoring divider.
interface nonrestoring_divider_if #(
    parameter int unsigned k = 8
);
    logic         start;
    logic [k-1:0] dividend;
    logic [k-1:0] divisor;
    logic         busy;
    logic         done;
    logic [k-1:0] quotient;
    logic [k-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/nonrestoring_divider.sv
// Sequential unsigned k-bit non-restoring divider: one add/subtract step per clock,
// then a single remainder-correction step. Shares the XOR-with-c / carry-in-c adder form of the Booth multiplier.
module nonrestoring_divider #(
    parameter int unsigned k = 8
) (
    input  logic                  clk,
    input  logic                  rst_b,
    nonrestoring_divider_if.slave bus
);
    localparam int unsigned AW = k + 1;
    localparam int unsigned CW = $clog2(k + 1);

    typedef enum logic [1:0] {IDLE, RUN, CORRECT, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] a_q, a_d;
    logic [k-1:0]  q_q, q_d;
    logic [k-1:0]  m_q, m_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [k-1:0]  quo_q, quo_d;
    logic [k-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Shared adder: c=1 subtracts M (A + ~M + 1), c=0 adds M.
    logic          sub_c;
    logic [AW-1:0] a_sh;
    logic [AW-1:0] m_ext;
    logic [AW-1:0] step_sum;
    logic [AW-1:0] corr_sum;

    assign sub_c    = ~a_q[k];
    assign a_sh     = {a_q[k-1:0], q_q[k-1]};
    assign m_ext    = {1'b0, m_q};
    assign step_sum = a_sh + (m_ext ^ {AW{sub_c}}) + AW'(sub_c);
    assign corr_sum = a_q + m_ext;

    // Next-state and next-register values.
    always_comb begin
        logic [AW-1:0] a_fix;
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        a_fix   = a_q[k] ? corr_sum : a_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d   = '0;
                    q_d   = bus.dividend;
                    m_d   = bus.divisor;
                    cnt_d = '0;
                    dbz_d = 1'b0;
                    if (bus.divisor == '0) begin
                        quo_d   = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                a_d   = step_sum;
                q_d   = {q_q[k-2:0], ~step_sum[k]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(k - 1)) state_d = CORRECT;
            end
            CORRECT: begin
                a_d     = a_fix;
                quo_d   = q_q;
                rem_d   = a_fix[k-1:0];
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_nonrestoring_divider.sv
// Bench for nonrestoring_divider: directed cases, handshake corner cases and a random sweep
// checked against plain integer division.
module tb_nonrestoring_divider;
    localparam int unsigned K = 8;
    localparam int NORMAL_LAT = K + 2;   // negedges after E0 until done is seen

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    nonrestoring_divider_if #(.k(K)) bus ();

    nonrestoring_divider #(.k(K)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural reference: plain integer division.
    task automatic ref_div(input logic [K-1:0] a, input logic [K-1:0] b,
                           output logic [K-1:0] qe, output logic [K-1:0] re, output logic dze);
        if (b == 0) begin
            qe = '1; re = a; dze = 1'b1;
        end else begin
            qe = K'(int'(a) / int'(b));
            re = K'(int'(a) % int'(b));
            dze = 1'b0;
        end
    endtask

    // Issue one division and wait (bounded) for done; busy must stay high until done.
    task automatic run_div(input logic [K-1:0] a, input logic [K-1:0] b,
                           output logic [K-1:0] qo, output logic [K-1:0] ro, output logic dz,
                           output int lat, output bit busy_ok, output bit timed_out);
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1; busy_ok = 1'b1; timed_out = 1'b0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (bus.done !== 1'b1) timed_out = 1'b1;
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
        qo = bus.quotient; ro = bus.remainder; dz = bus.div_by_zero;
    endtask

    task automatic test_reset();
        logic [2*K+2:0] got;
        #12;
        got = {bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", got);
        end
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic test_basic();
        logic [K-1:0] qo, ro; logic dz; int lat; bit bok, tmo;
        run_div(8'd100, 8'd7, qo, ro, dz, lat, bok, tmo);
        total++;
        if (tmo || lat != NORMAL_LAT) begin
            bad++; $display("FAIL basic_latency: got %0d timeout=%0d want %0d", lat, tmo, NORMAL_LAT);
        end
        total++;
        if ({qo, ro, dz} !== {8'd14, 8'd2, 1'b0}) begin
            bad++; $display("FAIL basic_result: got q=%0d r=%0d dz=%0d want q=14 r=2 dz=0", qo, ro, dz);
        end
        total++;
        if (!bok) begin
            bad++; $display("FAIL basic_busy: busy dropped before done, want high throughout");
        end
        @(negedge clk);
        total++;
        if ({bus.done, bus.busy, bus.quotient, bus.remainder} !== {1'b0, 1'b0, 8'd14, 8'd2}) begin
            bad++;
            $display("FAIL basic_after_done: got done=%0d busy=%0d q=%0d r=%0d want 0 0 14 2",
                     bus.done, bus.busy, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_edges();
        logic [K-1:0] ta [4] = '{8'd255, 8'd255, 8'd5, 8'd0};
        logic [K-1:0] tb [4] = '{8'd1,   8'd255, 8'd9, 8'd3};
        logic [K-1:0] tq [4] = '{8'd255, 8'd1,   8'd0, 8'd0};
        logic [K-1:0] tr [4] = '{8'd0,   8'd0,   8'd5, 8'd0};
        logic [K-1:0] qo, ro; logic dz; int lat; bit bok, tmo;
        for (int i = 0; i < 4; i++) begin
            run_div(ta[i], tb[i], qo, ro, dz, lat, bok, tmo);
            total++;
            if (tmo || lat != NORMAL_LAT || {qo, ro, dz} !== {tq[i], tr[i], 1'b0}) begin
                bad++;
                $display("FAIL edge_%0d_%0d: got q=%0d r=%0d dz=%0d lat=%0d want q=%0d r=%0d dz=0 lat=%0d",
                         ta[i], tb[i], qo, ro, dz, lat, tq[i], tr[i], NORMAL_LAT);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [K-1:0] qo, ro; logic dz; int lat; bit bok, tmo;
        run_div(8'd200, 8'd0, qo, ro, dz, lat, bok, tmo);
        total++;
        if (tmo || lat != 1 || {qo, ro, dz} !== {8'hFF, 8'd200, 1'b1}) begin
            bad++;
            $display("FAIL div_zero: got q=%h r=%0d dz=%0d lat=%0d want q=ff r=200 dz=1 lat=1", qo, ro, dz, lat);
        end
        run_div(8'd10, 8'd3, qo, ro, dz, lat, bok, tmo);
        total++;
        if (tmo || {qo, ro, dz} !== {8'd3, 8'd1, 1'b0}) begin
            bad++;
            $display("FAIL after_zero: got q=%0d r=%0d dz=%0d want q=3 r=1 dz=0", qo, ro, dz);
        end
    endtask

    task automatic test_ignore_start();
        logic [K-1:0] qo = '0, ro = '0;
        int pulses = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
        @(negedge clk);
        for (int i = 1; i <= 20; i++) begin
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                pulses++;
                qo = bus.quotient; ro = bus.remainder;
                bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
            end
            if (i == 3) begin
                bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        total++;
        if (pulses != 1 || {qo, ro} !== {8'd14, 8'd2}) begin
            bad++; $display("FAIL ignore_start: got pulses=%0d q=%0d r=%0d want 1 14 2", pulses, qo, ro);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL ignore_idle: got busy=%0d want 0", bus.busy);
        end
    endtask

    task automatic test_async_reset();
        logic [2*K+2:0] got;
        logic [K-1:0] qo, ro; logic dz; int lat; bit bok, tmo;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_b = 1'b0;
        #1;
        got = {bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder};
        total++;
        if (got !== '0) begin
            bad++; $display("FAIL async_reset: got %h want 0", got);
        end
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            bad++; $display("FAIL post_reset_idle: got busy=%0d done=%0d want 0 0", bus.busy, bus.done);
        end
        run_div(8'd63, 8'd8, qo, ro, dz, lat, bok, tmo);
        total++;
        if (tmo || {qo, ro, dz} !== {8'd7, 8'd7, 1'b0}) begin
            bad++; $display("FAIL after_reset_63_8: got q=%0d r=%0d dz=%0d want 7 7 0", qo, ro, dz);
        end
    endtask

    task automatic test_random();
        logic [K-1:0] a, b, qo, ro, qe, re; logic dz, dze; int lat; bit bok, tmo;
        for (int i = 0; i < 1000; i++) begin
            a = K'($urandom_range(0, 255));
            b = (i % 50 == 0) ? '0 : K'($urandom_range(0, 255));
            ref_div(a, b, qe, re, dze);
            run_div(a, b, qo, ro, dz, lat, bok, tmo);
            total++;
            if (tmo || !bok || lat != ((b == 0) ? 1 : NORMAL_LAT) || {qo, ro, dz} !== {qe, re, dze}) begin
                bad++;
                $display("FAIL random_%0d_%0d: got q=%0d r=%0d dz=%0d lat=%0d busy_ok=%0d want q=%0d r=%0d dz=%0d",
                         a, b, qo, ro, dz, lat, bok, qe, re, dze);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        test_reset();
        test_basic();
        test_edges();
        test_div_zero();
        test_ignore_start();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nonrestoring_divider.md
Name: nonrestoring_divider

Overview:
- Sequential unsigned k-bit divider. It is the inverse operation of the Booth multiplier datapath and is built around the same add/subtract structure: conditional XOR of M with a control bit c, feeding a ripple adder with carry-in c.
- Computes quotient and remainder of dividend/divisor using non-restoring division: one add-or-subtract step per clock, followed by a final remainder correction.
- Sits beside the multiplier in the arithmetic unit and uses a start/done handshake.

Parameters:
- k, 8, operand width in bits; quotient and remainder are both k bits.

Ports:
- clk  input  1  rising-edge clock
- rst_b  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  k  unsigned dividend (Q); sampled with start
- divisor  input  k  unsigned divisor (M); sampled with start
- busy  output  1  high from the cycle after start is accepted until done drops
- done  output  1  one-cycle pulse; results valid while high and held afterwards
- quotient  output  k  result quotient
- remainder  output  k  result remainder
- div_by_zero  output  1  set with done when divisor==0; cleared on the next accepted start

Behaviour:
- Reset (rst_b low, any time, including mid-division):
  - state IDLE
  - busy=0, done=0, div_by_zero=0
  - quotient=0, remainder=0
  - internal A, Q, M and counter cleared
- Internal registers:
  - A: k+1 bits, two's complement partial remainder
  - Q: k bits, dividend shifting into quotient
  - M: k bits, zero-extended to k+1 bits for the arithmetic
  - cnt: iteration counter, clog2(k+1) bits
- States: IDLE, RUN, CORRECT, DONE.
- IDLE:
  - start=1 at a rising edge loads A=0, Q=dividend, M=divisor, cnt=0, clears div_by_zero.
  - Next state is RUN, or DONE directly if divisor==0.
  - For divisor==0: quotient={k{1}}, remainder=dividend, div_by_zero=1.
- RUN, one iteration per edge:
  - Shift {A,Q} left 1.
  - If the pre-shift A[k]==0, A = A_shifted − M, implemented as A_shifted + ~M + 1 (c=1). Otherwise A = A_shifted + M (c=0).
  - New Q[0] = ~A_new[k].
  - cnt increments. After k iterations (cnt==k−1 at the edge), next state is CORRECT.
- CORRECT, one edge:
  - If A[k]==1, A = A + M.
  - quotient ← Q, remainder ← A[k-1:0]. Next state is DONE.
- DONE:
  - done=1 for exactly this one cycle; next edge returns to IDLE.
  - quotient, remainder and div_by_zero hold until the next accepted start.
- Latency:
  - Call the edge that accepts start E0. done is high in the cycle after edge E(k+1). For k=8, that is 9 edges after E0.
  - For divisor==0, done is high in the cycle after E0.
- busy=1 in RUN, CORRECT and DONE; busy=0 in IDLE.
- start while busy (including the DONE cycle) is ignored. Operands are not resampled, and no queueing occurs.
- Arithmetic is k+1 bits wide; the carry out of bit k is discarded. Remainder < divisor is guaranteed for divisor≠0, and quotient*divisor+remainder == dividend.
- Edge cases:
  - dividend < divisor yields quotient=0, remainder=dividend.
  - dividend==0 yields 0/0 outputs with div_by_zero=0 (when divisor≠0).

Test Plan:
- k=8, start with dividend=100, divisor=7 -> done exactly 9 edges after E0; quotient=14, remainder=2, div_by_zero=0; busy high for those 9 cycles.
- dividend=255, divisor=1 -> quotient=255, remainder=0. dividend=255, divisor=255 -> quotient=1, remainder=0.
- dividend=5, divisor=9 -> quotient=0, remainder=5. dividend=0, divisor=3 -> quotient=0, remainder=0.
- dividend=200, divisor=0 -> done in the cycle after E0; quotient=0xFF, remainder=200, div_by_zero=1. A following 10/3 clears div_by_zero and gives quotient=3, remainder=1.
- Start 100/7, then pulse start with 50/5 during RUN and during DONE -> both ignored; result still 14/2, and a single done pulse.
- Start 100/7, then assert rst_b=0 asynchronously at iteration 4 -> all outputs 0 immediately, state IDLE. After release, 63/8 completes with quotient=7, remainder=7. A random sweep of 1000 operand pairs is checked against a reference model.
